// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline constants and fetch entry type
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO with flush, used for fetch data and PC tags
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Flush wins over any same-cycle push or pop.
   assign do_push = push && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch: PC, imem request channel, fetch queue, IF/ID register
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          FQ_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stallD,
   output logic [31:0] instrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        validD
);
   localparam int CW = $clog2(FQ_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

   logic [XLEN-1:0] pc;
   logic [CW-1:0]   out_cnt, drop_cnt, out_cnt_next;
   logic [CW-1:0]   fq_count, tag_count;
   logic            fq_full, fq_empty, tag_full, tag_empty;
   logic [XLEN-1:0] tag_pc;
   fetch_entry_t    fq_head, rsp_entry, load_entry;
   logic            req_fire, rsp_drop, rsp_keep;
   logic            load, have_entry, bypass, fq_push, fq_pop;

   // Credit rule: every in-flight request owns a queue slot, so the queue never overflows.
   assign imem_req_valid = !rst && ((out_cnt + fq_count) < DEPTH_C);
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign out_cnt_next = out_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
   assign rsp_drop     = imem_rsp_valid && (drop_cnt != '0);
   assign rsp_keep     = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

   assign load       = !stallD || !validD;
   assign rsp_entry  = '{pc: tag_pc, instr: imem_rsp_data};
   assign bypass     = rsp_keep && fq_empty && load;
   assign fq_push    = rsp_keep && !bypass;
   assign fq_pop     = load && !fq_empty && !redirect_valid;
   assign have_entry = !fq_empty || rsp_keep;
   assign load_entry = fq_empty ? rsp_entry : fq_head;

   fetch_queue #(.DEPTH(FQ_DEPTH), .WIDTH(XLEN)) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_fire && !redirect_valid),
      .push_data (pc),
      .pop       (rsp_keep),
      .head      (tag_pc),
      .flush     (redirect_valid),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   fetch_queue #(.DEPTH(FQ_DEPTH), .WIDTH(2*XLEN)) u_fetch_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (fq_push),
      .push_data (rsp_entry),
      .pop       (fq_pop),
      .head      (fq_head),
      .flush     (redirect_valid),
      .count     (fq_count),
      .full      (fq_full),
      .empty     (fq_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= word_align(RESET_PC);
         out_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         out_cnt <= out_cnt_next;
         if (redirect_valid) begin
            pc       <= word_align(redirect_pc);
            drop_cnt <= out_cnt_next;
         end else begin
            if (req_fire) pc <= pc + 32'd4;
            if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         validD   <= 1'b0;
         instrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= 32'd4;
      end else if (redirect_valid) begin
         validD <= 1'b0;
         instrD <= NOP_INSTR;
      end else if (load) begin
         if (have_entry) begin
            validD   <= 1'b1;
            instrD   <= load_entry.instr;
            PCD      <= load_entry.pc;
            PCPlus4D <= load_entry.pc + 32'd4;
         end else begin
            validD <= 1'b0;
            instrD <= NOP_INSTR;
         end
      end
   end

   // Tags exist exactly for the live (non-dropped) requests.
   assert property (@(posedge clk) disable iff (rst) tag_count == out_cnt - drop_cnt);
   assert property (@(posedge clk) disable iff (rst) !(rsp_keep && tag_empty));
   assert property (@(posedge clk) disable iff (rst) !(req_fire && tag_full));
   assert property (@(posedge clk) disable iff (rst) !(fq_push && fq_full));

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISCV32I five-stage pipeline.
- Owns the program counter and issues word reads to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small fetch queue.
- Presents one instruction per cycle to the decode stage through the IF/ID output register (instrD, PCD, PCPlus4D, validD).
- Honours decode stalls and execute-stage branch/jump redirects, discarding wrong-path responses still in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- FQ_DEPTH, 2, fetch-queue entries and maximum in-flight requests; power of two, ≥2

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address (bits [1:0] always 0)
- imem_rsp_valid  in  1  read data valid; in request order, no backpressure, latency ≥1
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump taken in EX
- redirect_pc  in  32  target PC; bits [1:0] forced to 0 internally
- stallD  in  1  decode holds IF/ID register
- instrD  out  32  instruction to decode
- PCD  out  32  PC of instrD
- PCPlus4D  out  32  PCD + 4
- validD  out  1  instrD is a real instruction

## Operation
- State:
  - pc: 32 bits.
  - out_cnt: in-flight requests, 0..FQ_DEPTH.
  - drop_cnt: in-flight requests to discard, 0..FQ_DEPTH.
  - Fetch queue: entries {instr, pc}.
  - IF/ID register.
- Request issue:
  - imem_req_valid = !rst && (out_cnt + fq_count) < FQ_DEPTH.
  - imem_req_addr = pc.
  - On handshake: pc <= pc + 4 (mod 2^32), out_cnt++, and the request PC is pushed to a PC tag FIFO (part of the queue).
- Response handling:
  - If drop_cnt > 0: discard the response, drop_cnt--, out_cnt--.
  - Otherwise: out_cnt-- and pair the data with the oldest tagged PC.
  - The paired entry bypasses the queue straight into IF/ID if the queue is empty and IF/ID loads this cycle; otherwise it is enqueued.
- IF/ID load condition: !stallD || !validD.
  - On load: take the queue head, or the bypass entry, and set validD = 1.
  - If neither is available: validD = 0, instrD = 32'h0000_0013 (NOP), PCD/PCPlus4D hold.
- Redirect (highest priority, overrides stallD):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - Queue and PC tags flushed.
  - validD <= 0, instrD <= NOP.
  - drop_cnt <= out_cnt after this cycle's handshakes, i.e. requests accepted this cycle count and responses arriving this cycle are discarded.
- Queue overflow is impossible by credit rule; an assertion fires if a push occurs when full.
- Each outstanding request has a queue slot reserved by the credit rule.

## Timing
- Reset values:
  - imem_req_valid 0, imem_req_addr RESET_PC.
  - validD 0, instrD 32'h0000_0013, PCD 0, PCPlus4D 4.
  - pc RESET_PC; out_cnt, drop_cnt, and the queue cleared.
- First cycle after rst deasserts: imem_req_valid = 1, addr = RESET_PC.
- Latency: response accepted at edge N with an empty queue and IF/ID loading → instrD valid after edge N (same edge as capture).
- Throughput: one instruction per cycle with 1-cycle memory latency and FQ_DEPTH ≥ 2.
- Redirect at edge N:
  - First request with the new PC is possible in cycle N+1.
  - No wrong-path instruction appears on validD after edge N.
- stallD: while high with validD = 1, instrD/PCD/PCPlus4D are stable and responses fill the queue; requests stop when credits are exhausted.
- Reset asserted mid-operation clears all state at the next edge. Responses to pre-reset requests are the memory's responsibility to squash; the memory is also reset.
- pc wraps from 32'hFFFF_FFFC to 0 without error.

## Structure
- Shared package riscv_pkg: XLEN = 32, NOP_INSTR = 32'h0000_0013, default RESET_PC.
- Sub-module fetch_queue: synchronous FIFO, parameter DEPTH/WIDTH, with push, pop, flush, count, full, and empty. Instantiated once with width 64 for {pc, instr}; the PC tag FIFO is a second instance with width 32.
- Outputs are registered; the only combinational paths are imem_req_valid/addr from registered state.

## Test plan
- Reset, memory ready, latency 1 → requests 0x0, 0x4, 0x8 on consecutive cycles; instrD/PCD stream with validD continuously high from the third cycle.
- stallD high for 5 cycles with latency 1, FQ_DEPTH 2 → instrD/PCD frozen; at most 2 outstanding plus queued; after release, PCs continue in order with no gap or duplicate.
- redirect_valid with redirect_pc 0x100 while 2 requests are in flight (latency 3) → both responses dropped; next validD instruction has PCD 0x100; validD low in between.
- Redirect in the same cycle as a response and a request handshake → response discarded, handshaked request counted in drop_cnt, first valid PCD equals the target.
- redirect_pc 0x203 → imem_req_addr 0x200.
- PC wrap: RESET_PC 0xFFFF_FFF8 → PCDs FFFF_FFF8, FFFF_FFFC, 0, 4.
- Random imem_req_ready with latency 1–4 → PCD sequence strictly +4 and every instrD matches memory contents.
